// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the instruction/data memory arbiter.
// Holds the FSM state encoding and the memory access width codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IBUSY = 2'b01,
    ST_DBUSY = 2'b10
  } state_e;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, one transaction in flight.
// Data wins by default; a fetch that has waited through STARVE_LIMIT data grants goes next.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_rdata,
  output logic            imem_resp,
  output logic            imem_err,
  input  logic            dmem_req,
  input  logic            dmem_cmd,
  input  logic [1:0]      dmem_width,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_resp,
  output logic            dmem_err,
  output logic            mem_req,
  output logic            mem_cmd,
  output logic [1:0]      mem_width,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_resp,
  input  logic            mem_err
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_cmd_q, mem_cmd_d;
  logic [1:0]        mem_width_q, mem_width_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              grant_imem_c;

  // Grant decision, payload capture and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = 1'b0;
    mem_cmd_d    = mem_cmd_q;
    mem_width_d  = mem_width_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    starve_cnt_d = starve_cnt_q;
    grant_imem_c = imem_req & (~dmem_req | (starve_cnt_q >= CNT_MAX));

    case (state_q)
      ST_IDLE: begin
        if (imem_req | dmem_req) begin
          mem_req_d = 1'b1;
          if (grant_imem_c) begin
            state_d      = ST_IBUSY;
            mem_cmd_d    = 1'b0;
            mem_width_d  = WIDTH_WORD;
            mem_addr_d   = imem_addr;
            mem_wdata_d  = '0;
            starve_cnt_d = '0;
          end else begin
            state_d     = ST_DBUSY;
            mem_cmd_d   = dmem_cmd;
            mem_width_d = dmem_width;
            mem_addr_d  = dmem_addr;
            mem_wdata_d = dmem_wdata;
            // Only count data grants that actually made a fetch wait.
            if (imem_req && (starve_cnt_q < CNT_MAX)) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (mem_resp | mem_err) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_cmd_q    <= 1'b0;
      mem_width_q  <= WIDTH_BYTE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_width_q  <= mem_width_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_width = mem_width_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Responses are steered to the owner in the same cycle; an error suppresses resp.
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign imem_resp  = (state_q == ST_IBUSY) & mem_resp & ~mem_err;
  assign imem_err   = (state_q == ST_IBUSY) & mem_err;
  assign dmem_resp  = (state_q == ST_DBUSY) & mem_resp & ~mem_err;
  assign dmem_err   = (state_q == ST_DBUSY) & mem_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_resp, imem_err;
  logic            dmem_req, dmem_cmd;
  logic [1:0]      dmem_width;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_resp, dmem_err;
  logic            mem_req, mem_cmd;
  logic [1:0]      mem_width;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_resp, mem_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_err(dmem_err),
    .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'b00;
    dmem_addr = '0; dmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0; mem_err = 1'b0;
  endtask

  // Transaction-level reference state for the random phase
  bit              m_busy, m_own_d, m_req;
  int unsigned     m_starve;
  logic            m_cmd;
  logic [1:0]      m_width;
  logic [31:0]     m_addr, m_wdata;
  bit              i_act, d_act, mem_pend;
  int              mem_cnt;
  int              igr, dgr;
  bit              pick_i;

  initial begin
    clear_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_cmd", 32'(mem_cmd), 32'd0);
    check("rst_mem_width", 32'(mem_width), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resps", 32'({imem_resp, dmem_resp, imem_err, dmem_err}), 32'd0);
    check("rst_starve", 32'(dut.starve_cnt_q), 32'd0);

    // Lone fetch
    imem_req = 1'b1; imem_addr = 32'h100;
    #1;
    check("lf_c0_req", 32'(mem_req), 32'd0);
    step();
    check("lf_c1_req", 32'(mem_req), 32'd1);
    check("lf_addr", mem_addr, 32'h100);
    check("lf_cmd_width", 32'({mem_cmd, mem_width}), 32'b010);
    step();
    check("lf_c2_req", 32'(mem_req), 32'd0);
    step();
    mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("lf_iresp", 32'(imem_resp), 32'd1);
    check("lf_irdata", imem_rdata, 32'hDEADBEEF);
    check("lf_dresp", 32'(dmem_resp), 32'd0);
    step();
    mem_resp = 1'b0; imem_req = 1'b0;
    step();

    // Simultaneous requests: data first, then fetch
    imem_req = 1'b1; imem_addr = 32'h300;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'b00;
    dmem_addr = 32'h200; dmem_wdata = 32'h55;
    #1;
    step();
    check("sim_req1", 32'(mem_req), 32'd1);
    check("sim_cmd1", 32'(mem_cmd), 32'd1);
    check("sim_width1", 32'(mem_width), 32'd0);
    check("sim_addr1", mem_addr, 32'h200);
    check("sim_wdata1", mem_wdata, 32'h55);
    dmem_addr = 32'hBAD0; imem_addr = 32'hBAD4;
    step();
    check("sim_hold_addr", mem_addr, 32'h200);
    mem_resp = 1'b1;
    #1;
    check("sim_dresp", 32'(dmem_resp), 32'd1);
    check("sim_iresp0", 32'(imem_resp), 32'd0);
    step();
    mem_resp = 1'b0; dmem_req = 1'b0; imem_addr = 32'h300;
    #1;
    check("sim_no_req_in_idle", 32'(mem_req), 32'd0);
    step();
    check("sim_req2", 32'(mem_req), 32'd1);
    check("sim_addr2", mem_addr, 32'h300);
    check("sim_cmd2", 32'(mem_cmd), 32'd0);
    step();
    mem_resp = 1'b1; mem_rdata = 32'h1234;
    #1;
    check("sim_iresp", 32'(imem_resp), 32'd1);
    step();
    mem_resp = 1'b0; imem_req = 1'b0;
    step();

    // Starvation: fetch held, data re-requests continuously
    imem_req = 1'b1; imem_addr = 32'h400;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 32'h800;
    #1;
    for (int g = 0; g < 5; g++) begin
      step();
      check("stv_req", 32'(mem_req), 32'd1);
      check("stv_addr", mem_addr, (g < 4) ? 32'h800 : 32'h400);
      check("stv_cnt", 32'(dut.starve_cnt_q), (g < 4) ? 32'(g + 1) : 32'd0);
      step();
      mem_resp = 1'b1; mem_rdata = 32'(g);
      #1;
      check("stv_iresp", 32'(imem_resp), (g < 4) ? 32'd0 : 32'd1);
      check("stv_dresp", 32'(dmem_resp), (g < 4) ? 32'd1 : 32'd0);
      step();
      mem_resp = 1'b0;
      if (g == 4) begin imem_req = 1'b0; dmem_req = 1'b0; end
      #1;
    end
    step();

    // Error on a data read
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_addr = 32'h900;
    step();
    check("err_req", 32'(mem_req), 32'd1);
    step();
    mem_err = 1'b1;
    #1;
    check("err_derr", 32'(dmem_err), 32'd1);
    check("err_dresp", 32'(dmem_resp), 32'd0);
    check("err_ierr", 32'(imem_err), 32'd0);
    step();
    mem_err = 1'b0; dmem_req = 1'b0;
    #1;
    check("err_state", 32'(dut.state_q), 32'(ST_IDLE));
    step();
    check("err_no_req", 32'(mem_req), 32'd0);

    // Reset while a data transaction is in flight
    dmem_req = 1'b1; dmem_addr = 32'hA00;
    step();
    check("rb_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    check("rb_req_in_rst0", 32'(mem_req), 32'd0);
    step();
    check("rb_req_in_rst1", 32'(mem_req), 32'd0);
    rst = 1'b0; dmem_req = 1'b0;
    step();
    mem_resp = 1'b1;
    #1;
    check("rb_late_dresp", 32'(dmem_resp), 32'd0);
    check("rb_late_iresp", 32'(imem_resp), 32'd0);
    step();
    mem_resp = 1'b0;

    // Spurious response in IDLE
    mem_resp = 1'b1; mem_err = 1'b1;
    #1;
    check("sp_resps", 32'({imem_resp, dmem_resp, imem_err, dmem_err}), 32'd0);
    step();
    mem_resp = 1'b0; mem_err = 1'b0;
    check("sp_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("sp_no_req", 32'(mem_req), 32'd0);

    // Randomized traffic against the reference model
    m_busy = 1'b0; m_own_d = 1'b0; m_req = 1'b0; m_starve = 0;
    m_cmd = 1'b0; m_width = 2'b00; m_addr = '0; m_wdata = '0;
    i_act = 1'b0; d_act = 1'b0; mem_pend = 1'b0; mem_cnt = 0;
    igr = 0; dgr = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      mem_resp = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_pend = 1'b0;
          if ($urandom_range(0, 4) == 0) begin
            mem_err = 1'b1;
            mem_resp = 1'($urandom_range(0, 1));
          end else begin
            mem_resp = 1'b1;
          end
        end
      end else if (!m_busy && $urandom_range(0, 19) == 0) begin
        mem_resp = 1'b1;
        mem_err = 1'($urandom_range(0, 1));
      end
      if (!i_act) begin
        if ($urandom_range(0, 2) == 0) begin i_act = 1'b1; imem_addr = $urandom; end
      end else if ($urandom_range(0, 3) == 0) imem_addr = $urandom;
      if (!d_act) begin
        if ($urandom_range(0, 1) == 0) d_act = 1'b1;
      end
      if (!d_act || $urandom_range(0, 3) == 0) begin
        dmem_cmd = 1'($urandom_range(0, 1));
        dmem_width = 2'($urandom_range(0, 2));
        dmem_addr = $urandom;
        dmem_wdata = $urandom;
      end
      imem_req = i_act;
      dmem_req = d_act;
      #1;

      check("rnd_mem_req", 32'(mem_req), 32'(m_req));
      if (m_busy) begin
        check("rnd_cmd", 32'(mem_cmd), 32'(m_cmd));
        check("rnd_width", 32'(mem_width), 32'(m_width));
        check("rnd_addr", mem_addr, m_addr);
        check("rnd_wdata", mem_wdata, m_wdata);
      end
      check("rnd_iresp", 32'(imem_resp), 32'(m_busy && !m_own_d && mem_resp && !mem_err));
      check("rnd_ierr", 32'(imem_err), 32'(m_busy && !m_own_d && mem_err));
      check("rnd_dresp", 32'(dmem_resp), 32'(m_busy && m_own_d && mem_resp && !mem_err));
      check("rnd_derr", 32'(dmem_err), 32'(m_busy && m_own_d && mem_err));
      check("rnd_irdata", imem_rdata, mem_rdata);
      check("rnd_drdata", dmem_rdata, mem_rdata);

      // Advance the model by one cycle
      m_req = 1'b0;
      if (m_busy) begin
        if (mem_resp || mem_err) m_busy = 1'b0;
      end else if (imem_req || dmem_req) begin
        pick_i = imem_req && (!dmem_req || m_starve >= LIMIT);
        m_busy = 1'b1;
        m_req = 1'b1;
        m_own_d = !pick_i;
        if (pick_i) begin
          m_cmd = 1'b0; m_width = 2'b10; m_addr = imem_addr; m_wdata = '0;
          m_starve = 0;
          igr++;
        end else begin
          m_cmd = dmem_cmd; m_width = dmem_width; m_addr = dmem_addr; m_wdata = dmem_wdata;
          if (imem_req && m_starve < LIMIT) m_starve++;
          dgr++;
        end
      end

      if (imem_resp || imem_err) i_act = 1'b0;
      if (dmem_resp || dmem_err) d_act = 1'b0;
      if (mem_req) begin
        mem_pend = 1'b1;
        mem_cnt = $urandom_range(1, 3);
      end
    end
    check("rnd_saw_igrants", 32'(igr > 50), 32'd1);
    check("rnd_saw_dgrants", 32'(dgr > 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
